shop_cmd_tx: RTL
================

// Module: shop_cmd_tx
// PURPOSE
//  Command-frame transmitter for the shop command processor. Drives the processor's input handshake (rdy, u, a).
//  Takes one encoded command (keyword code, user ID, 0..2 argument words).
//  Serialises the command as a frame of 24-bit ASCII words on o_a, with a one-cycle o_rdy strobe for each word.
//  Sits between the host/test sequencer and the shop core's command input.
// PARAMETERS
//  O_A_NUM_BITS  24  word width; fixed at 3 ASCII chars, MSB-first
//  O_U_NUM_BITS   4  user ID width
//  MAX_USERS      5  valid user IDs are 0..MAX_USERS-1 (admin included)
//  GAP_CYCLES     1  o_rdy-low cycles inserted between consecutive words; legal range 0..15
// PORTS
//  i_clk      in   1   clock; all state updates on the rising edge
//  i_reset    in   1   asynchronous reset, active-low
//  i_start    in   1   request; sampled only while o_busy=0
//  i_cmd      in   3   0 Logout, 1 Login, 2 AddUsr, 3 DelUsr, 4 AddItem, 5 DelItem, 6 Buy, 7 NONE
//  i_user     in   4   user ID for the frame
//  i_nargs    in   2   argument word count; value 3 is treated as 2
//  i_arg0     in   24  first argument word (ASCII)
//  i_arg1     in   24  second argument word (ASCII)
//  o_rdy      out  1   word strobe toward the shop core
//  o_u        out  4   user ID; held stable for the whole frame
//  o_a        out  24  current word; holds its last value between strobes
//  o_busy     out  1   frame in progress
//  o_done     out  1   1-cycle pulse: frame complete
//  o_err      out  1   1-cycle pulse: request rejected
// BEHAVIOUR
//  Reset (async, i_reset=0)
//   - All outputs go to 0 immediately; state=IDLE.
//   - A frame in flight is abandoned; no o_done is produced.
//  States: IDLE -> WORD <-> GAP -> FIN -> IDLE
//  Request acceptance (IDLE)
//   - i_start=1 with i_user<MAX_USERS: latch cmd/user/nargs/args, go to WORD; o_busy=1 next cycle.
//   - i_start=1 with i_user>=MAX_USERS: pulse o_err next cycle; no frame; stay IDLE.
//  Keyword encoding
//   - Keyword is a 72-bit ROM entry, left-justified, zero-padded.
//   - Keyword words are sent MSB-first until an all-zero word or 3 words.
//   - Logout: "Log","out"          Login: "Log","in\0"
//   - AddUsr: "Add","Usr"          DelUsr: "Del","Usr"
//   - AddItem: "Add","Ite","m\0\0" DelItem: "Del","Ite","m\0\0"
//   - Buy: "Buy"                   NONE: "NON","E\0\0"
//   - Argument words follow the keyword: arg0, then arg1. They are sent verbatim, including all-zero words.
//  Timing (frame of n words, start accepted at cycle 0)
//   - WORD: o_rdy=1 for exactly 1 cycle; o_a=word k; word k appears at cycle 1+k*(GAP_CYCLES+1).
//   - GAP: o_rdy=0 for GAP_CYCLES cycles; o_a holds.
//   - After the last word there is no gap; go to FIN.
//   - FIN: o_done=1 and o_busy=0 at cycle 2+(n-1)*(GAP_CYCLES+1).
//   - The cycle after the last word always has o_rdy=0, so frames never merge.
//  Request handling while busy
//   - i_start while o_busy=1 is ignored; it is neither queued nor flagged.
//   - i_start in the FIN cycle is accepted: FIN behaves as IDLE for acceptance.
//  Counters
//   - Word counter is 3 bits, max 6 words (3 keyword + 2 args + 1 checksum).
//   - Gap counter is 4 bits and is reloaded every WORD cycle.
//  o_u
//   - Updates only at acceptance; holds its value after the frame until the next acceptance.
// CONFIGURATION
//  SHOP_TX_CHECKSUM_EN defined
//   - After the last argument word, append one trailer word with the normal gap rule.
//   - Trailer = XOR of all preceding words in the frame; n increases by 1.
//  SHOP_TX_CHECKSUM_EN undefined
//   - No trailer word; no XOR logic is generated.
// TESTING (GAP_CYCLES=1, checksum off unless noted)
//  1. Reset mid-frame: assert i_reset=0 during a word -> o_rdy/o_busy/o_a=0 in the same cycle; o_done never pulses.
//  2. cmd=6, user=2, nargs=1, arg0="abc" -> "Buy"@c1, "abc"@c3, rdy=0@c2, done@c4, o_u=2 throughout.
//  3. cmd=4, user=0, nargs=2 ("pen","005") -> "Add","Ite","m\0\0","pen","005"@c1,3,5,7,9; done@c10.
//  4. user=5 (=MAX_USERS) with start -> o_err@c1; o_rdy stays 0; o_busy stays 0.
//  5. Start held high across the frame, re-asserted in the FIN cycle -> exactly 2 frames, 1 rdy-low cycle between them.
//  6. SHOP_TX_CHECKSUM_EN, cmd=6, nargs=0 -> "Buy"@c1, trailer 0x427579 ("Buy")@c3, done@c4.

Source files
------------

// File: rtl/shop_cmd_tx.sv
// -----------------------------------------------------------------------------
// shop_cmd_tx
//   Command-frame transmitter for the shop command processor. Accepts one
//   encoded command (keyword code, user ID, 0..2 argument words) and
//   serialises it as a frame of 24-bit ASCII words on o_a. Each word is
//   marked by a one-cycle o_rdy strobe. GAP_CYCLES idle cycles separate
//   consecutive words.
//
//   Optional feature macro: SHOP_TX_CHECKSUM_EN
//     defined   -> one trailer word is appended to every frame. The trailer is
//                  the XOR of all preceding words in that frame.
//     undefined -> no trailer word and no XOR logic.
//
// Ports
//   i_clk    in   1   clock, rising edge
//   i_reset  in   1   asynchronous reset, active-low
//   i_start  in   1   frame request (honoured in IDLE and FIN only)
//   i_cmd    in   3   keyword code 0..7
//   i_user   in   4   user ID; IDs >= MAX_USERS are rejected with o_err
//   i_nargs  in   2   argument word count (3 behaves as 2)
//   i_arg0   in  24   first argument word
//   i_arg1   in  24   second argument word
//   o_rdy    out  1   word strobe
//   o_u      out  4   user ID of the latest accepted frame
//   o_a      out 24   current word; holds its value between strobes
//   o_busy   out  1   frame in progress
//   o_done   out  1   one-cycle pulse at frame completion
//   o_err    out  1   one-cycle pulse for a rejected request
// -----------------------------------------------------------------------------
module shop_cmd_tx #(
    parameter int O_A_NUM_BITS = 24,
    parameter int O_U_NUM_BITS = 4,
    parameter int MAX_USERS    = 5,
    parameter int GAP_CYCLES   = 1
) (
    input  logic                    i_clk,
    input  logic                    i_reset,
    input  logic                    i_start,
    input  logic [2:0]              i_cmd,
    input  logic [O_U_NUM_BITS-1:0] i_user,
    input  logic [1:0]              i_nargs,
    input  logic [O_A_NUM_BITS-1:0] i_arg0,
    input  logic [O_A_NUM_BITS-1:0] i_arg1,
    output logic                    o_rdy,
    output logic [O_U_NUM_BITS-1:0] o_u,
    output logic [O_A_NUM_BITS-1:0] o_a,
    output logic                    o_busy,
    output logic                    o_done,
    output logic                    o_err
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_WORD = 2'd1,
        ST_GAP  = 2'd2,
        ST_FIN  = 2'd3
    } state_t;

    localparam logic [O_U_NUM_BITS-1:0] USER_LIMIT = O_U_NUM_BITS'(MAX_USERS);
    localparam logic [3:0]              GAP_RELOAD = 4'(GAP_CYCLES);
`ifdef SHOP_TX_CHECKSUM_EN
    localparam logic [2:0]              TRAILER_WORDS = 3'd1;
`else
    localparam logic [2:0]              TRAILER_WORDS = 3'd0;
`endif

    // Keyword ROM: three left-justified ASCII words, zero padded.
    function automatic logic [71:0] kw_rom(input logic [2:0] cmd);
        logic [71:0] kw;
        case (cmd)
            3'd0:    kw = {24'h4C6F67, 24'h6F7574, 24'h000000}; // "Log" "out"
            3'd1:    kw = {24'h4C6F67, 24'h696E00, 24'h000000}; // "Log" "in"
            3'd2:    kw = {24'h416464, 24'h557372, 24'h000000}; // "Add" "Usr"
            3'd3:    kw = {24'h44656C, 24'h557372, 24'h000000}; // "Del" "Usr"
            3'd4:    kw = {24'h416464, 24'h497465, 24'h6D0000}; // "Add" "Ite" "m"
            3'd5:    kw = {24'h44656C, 24'h497465, 24'h6D0000}; // "Del" "Ite" "m"
            3'd6:    kw = {24'h427579, 24'h000000, 24'h000000}; // "Buy"
            3'd7:    kw = {24'h4E4F4E, 24'h450000, 24'h000000}; // "NON" "E"
            default: kw = 72'h0;
        endcase
        return kw;
    endfunction

    // Number of keyword words: stop at the first all-zero word (word 0 is never zero).
    function automatic logic [2:0] kw_len(input logic [71:0] kw);
        logic [2:0] len;
        if (kw[47:24] == 24'h000000) begin
            len = 3'd1;
        end else if (kw[23:0] == 24'h000000) begin
            len = 3'd2;
        end else begin
            len = 3'd3;
        end
        return len;
    endfunction

`ifdef SHOP_TX_CHECKSUM_EN
    // Running frame checksum: fold one more word into the accumulator.
    function automatic logic [O_A_NUM_BITS-1:0] csum_fold(input logic [O_A_NUM_BITS-1:0] acc,
                                                          input logic [O_A_NUM_BITS-1:0] word);
        return acc ^ word;
    endfunction
`endif

    state_t                  state_r;
    logic [2:0]              cmd_r;
    logic [1:0]              nargs_r;
    logic [O_A_NUM_BITS-1:0] arg0_r;
    logic [O_A_NUM_BITS-1:0] arg1_r;
    logic [2:0]              n_words_r;
    logic [2:0]              word_idx_r;
    logic [3:0]              gap_cnt_r;
`ifdef SHOP_TX_CHECKSUM_EN
    logic [O_A_NUM_BITS-1:0] csum_r;
`endif

    logic [71:0]             kw_s;
    logic [2:0]              kw_len_s;
    logic [2:0]              next_idx_s;
    logic [O_A_NUM_BITS-1:0] next_word_s;
    logic [71:0]             start_kw_s;
    logic [1:0]              start_nargs_s;
    logic [2:0]              start_n_s;
    logic                    user_ok_s;
    logic                    last_word_s;

    // Request-side decode: effective arg count, frame length, user validity.
    always_comb begin
        start_kw_s    = kw_rom(i_cmd);
        start_nargs_s = (i_nargs == 2'd3) ? 2'd2 : i_nargs;
        start_n_s     = kw_len(start_kw_s) + {1'b0, start_nargs_s} + TRAILER_WORDS;
        user_ok_s     = (i_user < USER_LIMIT);
    end

    // Select the word following the one currently on o_a: keyword, args, then trailer.
    always_comb begin
        kw_s        = kw_rom(cmd_r);
        kw_len_s    = kw_len(kw_s);
        next_idx_s  = word_idx_r + 3'd1;
        last_word_s = (word_idx_r == (n_words_r - 3'd1));
        next_word_s = '0;
        if (next_idx_s < kw_len_s) begin
            case (next_idx_s)
                3'd1:    next_word_s = kw_s[47:24];
                3'd2:    next_word_s = kw_s[23:0];
                default: next_word_s = kw_s[71:48];
            endcase
        end else if ((next_idx_s == kw_len_s) && (nargs_r != 2'd0)) begin
            next_word_s = arg0_r;
        end else if ((next_idx_s == (kw_len_s + 3'd1)) && (nargs_r == 2'd2)) begin
            next_word_s = arg1_r;
        end else begin
`ifdef SHOP_TX_CHECKSUM_EN
            next_word_s = csum_r;
`else
            next_word_s = '0;
`endif
        end
    end

    // Frame FSM with registered handshake outputs.
    always_ff @(posedge i_clk or negedge i_reset) begin
        if (!i_reset) begin
            state_r    <= ST_IDLE;
            cmd_r      <= 3'd0;
            nargs_r    <= 2'd0;
            arg0_r     <= '0;
            arg1_r     <= '0;
            n_words_r  <= 3'd0;
            word_idx_r <= 3'd0;
            gap_cnt_r  <= 4'd0;
`ifdef SHOP_TX_CHECKSUM_EN
            csum_r     <= '0;
`endif
            o_rdy      <= 1'b0;
            o_u        <= '0;
            o_a        <= '0;
            o_busy     <= 1'b0;
            o_done     <= 1'b0;
            o_err      <= 1'b0;
        end else begin
            o_rdy  <= 1'b0;
            o_done <= 1'b0;
            o_err  <= 1'b0;
            case (state_r)
                // FIN accepts a new request exactly like IDLE.
                ST_IDLE, ST_FIN: begin
                    o_busy <= 1'b0;
                    if (i_start && user_ok_s) begin
                        cmd_r      <= i_cmd;
                        nargs_r    <= start_nargs_s;
                        arg0_r     <= i_arg0;
                        arg1_r     <= i_arg1;
                        n_words_r  <= start_n_s;
                        word_idx_r <= 3'd0;
`ifdef SHOP_TX_CHECKSUM_EN
                        csum_r     <= start_kw_s[71:48];
`endif
                        o_u        <= i_user;
                        o_a        <= start_kw_s[71:48];
                        o_rdy      <= 1'b1;
                        o_busy     <= 1'b1;
                        state_r    <= ST_WORD;
                    end else if (i_start) begin
                        o_err   <= 1'b1;
                        state_r <= ST_IDLE;
                    end else begin
                        state_r <= ST_IDLE;
                    end
                end
                ST_WORD: begin
                    gap_cnt_r <= GAP_RELOAD;
                    if (last_word_s) begin
                        o_busy  <= 1'b0;
                        o_done  <= 1'b1;
                        state_r <= ST_FIN;
                    end else if (GAP_CYCLES == 0) begin
                        o_a        <= next_word_s;
                        o_rdy      <= 1'b1;
                        word_idx_r <= next_idx_s;
`ifdef SHOP_TX_CHECKSUM_EN
                        csum_r     <= csum_fold(csum_r, next_word_s);
`endif
                        state_r    <= ST_WORD;
                    end else begin
                        state_r <= ST_GAP;
                    end
                end
                ST_GAP: begin
                    // The counter was loaded with GAP_CYCLES; leave after that many gap cycles.
                    if (gap_cnt_r <= 4'd1) begin
                        o_a        <= next_word_s;
                        o_rdy      <= 1'b1;
                        word_idx_r <= next_idx_s;
`ifdef SHOP_TX_CHECKSUM_EN
                        csum_r     <= csum_fold(csum_r, next_word_s);
`endif
                        state_r    <= ST_WORD;
                    end else begin
                        gap_cnt_r <= gap_cnt_r - 4'd1;
                        state_r   <= ST_GAP;
                    end
                end
                default: begin
                    o_busy  <= 1'b0;
                    state_r <= ST_IDLE;
                end
            endcase
        end
    end

endmodule
